// File: rtl/proc_pkg.sv
// proc_pkg: shared opcodes, branch condition codes, flag indices and instruction helpers
package proc_pkg;
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR = 4'h3;
  localparam logic [3:0] OP_LDA = 4'h4, OP_LDB = 4'h5, OP_NOP = 4'h6;
  localparam logic [2:0] BR_ALWAYS = 3'd0, BR_Z = 3'd1, BR_NZ = 3'd2, BR_N = 3'd3;
  localparam logic [2:0] BR_C = 3'd4, BR_V = 3'd5, BR_NN = 3'd6, BR_NEVER = 3'd7;
  localparam int F_N = 3, F_Z = 2, F_C = 1, F_V = 0;
  typedef struct packed {
    logic [3:0] op;
    logic [7:0] arg;
  } instr_t;
  function automatic logic two_byte(input logic [3:0] op);
    return op[3] || op == OP_LDA || op == OP_LDB;
  endfunction
  function automatic logic branch_cond(input logic [2:0] c, input logic [3:0] f);
    return c == BR_ALWAYS ? 1'b1 :
           c == BR_Z      ? f[F_Z] :
           c == BR_NZ     ? !f[F_Z] :
           c == BR_N      ? f[F_N] :
           c == BR_C      ? f[F_C] :
           c == BR_V      ? f[F_V] :
           c == BR_NN     ? !f[F_N] : 1'b0;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy level; caller never overflows or underflows it
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  assign dout  = mem[rptr];
  assign full  = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  // storage array, written at the tail
  always_ff @(posedge clk) if (wr) mem[wptr] <= din;
  // pointers wrap naturally since depth is a power of two
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      level <= level + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/instr_issue.sv
// instr_issue: assembles UART bytes into instructions, queues them and issues one per exec_ready
module instr_issue
  import proc_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int ARG_TIMEOUT = 50000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  input  logic                          exec_ready,
  input  logic [3:0]                    flags,
  output logic [3:0]                    OPcode,
  output logic                          en,
  output logic [7:0]                    operand,
  output logic                          branch_taken,
  output logic                          rx_ready,
  output logic                          frame_err,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int CW = $clog2(ARG_TIMEOUT + 1);
  localparam logic [0:0] S_OP = 1'b0, S_ARG = 1'b1;
  logic [0:0]    state;
  logic [3:0]    lat_op;
  logic [CW-1:0] cnt;
  logic [3:0]    rx_op;
  logic          push, pop, wr, full, empty;
  instr_t        push_data, head;
  assign rx_op     = rx_data[7:4];
  assign push      = rx_valid && (state == S_ARG || !two_byte(rx_op));
  assign push_data = state == S_ARG ? '{op: lat_op, arg: rx_data} : '{op: rx_op, arg: 8'h00};
  assign pop       = !empty && exec_ready;
  assign wr        = push && (!full || pop);
  assign rx_ready  = !full;
  sync_fifo #(.WIDTH(12), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .wr(wr), .din(push_data), .rd(pop),
    .dout(head), .level(fifo_level), .full(full), .empty(empty)
  );
  // byte assembler: opcode byte, optional argument byte, abandoned after ARG_TIMEOUT idle cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= S_OP;
      lat_op    <= '0;
      cnt       <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (state == S_OP) begin
        if (rx_valid && two_byte(rx_op)) begin
          state  <= S_ARG;
          lat_op <= rx_op;
          cnt    <= '0;
        end
      end else if (rx_valid) state <= S_OP;
      else if (cnt == CW'(ARG_TIMEOUT - 1)) begin
        state     <= S_OP;
        frame_err <= 1'b1;
      end else cnt <= cnt + 1'b1;
    end
  // issue stage: register queue head on pop, evaluate branch with flags of the pop cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      OPcode       <= '0;
      operand      <= '0;
      en           <= 1'b0;
      branch_taken <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      en           <= pop;
      ovf          <= push && full && !pop;
      branch_taken <= pop && head.op[3] && branch_cond(head.op[2:0], flags);
      if (pop) begin
        OPcode  <= head.op;
        operand <= head.arg;
      end
    end
endmodule

// File: tb/tb_instr_issue.sv
// tb_instr_issue: randomized + directed scoreboard bench for instr_issue
module tb_instr_issue;
  localparam int D = 4, TO = 20;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0, exec_ready = 1'b0;
  logic [3:0] flags = '0;
  logic [3:0] OPcode;
  logic       en, branch_taken, rx_ready, frame_err, ovf;
  logic [7:0] operand;
  logic [2:0] fifo_level;

  instr_issue #(.FIFO_DEPTH(D), .ARG_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .exec_ready(exec_ready), .flags(flags), .OPcode(OPcode), .en(en),
    .operand(operand), .branch_taken(branch_taken), .rx_ready(rx_ready),
    .frame_err(frame_err), .ovf(ovf), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] arg;
    logic       bt;
  } ent_t;

  ent_t mq[$];
  ent_t exq[$];
  ent_t mon_e;
  int n_chk = 0, n_fail = 0;
  int exp_ovf = 0, exp_ferr = 0, got_ovf = 0, got_ferr = 0;
  bit pend = 0;
  logic [3:0] pend_op = '0;
  int idle = 0;
  logic [3:0] last_op = '0;
  logic [7:0] last_arg = '0;

  function automatic logic taken(input logic [3:0] op, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    if (!op[3]) return 1'b0;
    case (op[2:0])
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return n;
      3'd4: return c;
      3'd5: return v;
      3'd6: return !n;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // monitor: every issue must match the head of the expected queue
  always @(negedge clk) if (rst_n) begin
    if (ovf) got_ovf++;
    if (frame_err) got_ferr++;
    if (en) begin
      if (exq.size() == 0) chk("unexpected_en", 1, 0);
      else begin
        mon_e = exq.pop_front();
        chk("opcode", OPcode, mon_e.op);
        chk("operand", operand, mon_e.arg);
        chk("branch_taken", branch_taken, mon_e.bt);
        last_op = mon_e.op;
        last_arg = mon_e.arg;
      end
    end else begin
      chk("hold_opcode", OPcode, last_op);
      chk("hold_operand", operand, last_arg);
      chk("branch_taken_idle", branch_taken, 0);
    end
  end

  task automatic cycle(input logic rv, input logic [7:0] d, input logic er, input logic [3:0] f);
    ent_t e, h;
    bit pop, done;
    int sz;
    @(negedge clk); #1;
    chk("fifo_level", fifo_level, mq.size());
    chk("rx_ready", rx_ready, mq.size() < D);
    rx_valid = rv; rx_data = d; exec_ready = er; flags = f;
    sz = mq.size();
    pop = sz > 0 && er;
    done = 0;
    e.op = '0; e.arg = '0; e.bt = 1'b0;
    if (!pend) begin
      if (rv) begin
        if (d[7] || d[7:4] == 4'h4 || d[7:4] == 4'h5) begin
          pend = 1; pend_op = d[7:4]; idle = 0;
        end else begin
          done = 1; e.op = d[7:4];
        end
      end
    end else if (rv) begin
      done = 1; e.op = pend_op; e.arg = d; pend = 0;
    end else begin
      idle++;
      if (idle == TO) begin pend = 0; exp_ferr++; end
    end
    if (pop) begin
      h = mq.pop_front();
      h.bt = taken(h.op, f);
      exq.push_back(h);
    end
    if (done) begin
      if (sz < D || pop) mq.push_back(e);
      else exp_ovf++;
    end
  endtask

  task automatic idle_n(input int n, input logic er, input logic [3:0] f);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, er, f);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0; rx_valid = 1'b0; exec_ready = 1'b0;
    chk("exq_empty_at_reset", exq.size(), 0);
    mq.delete(); exq.delete();
    pend = 0; idle = 0; last_op = '0; last_arg = '0;
    repeat (2) @(negedge clk);
    chk("rst_opcode", OPcode, 0);
    chk("rst_operand", operand, 0);
    chk("rst_en", en, 0);
    chk("rst_branch", branch_taken, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_ovf", ovf, 0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int o0, f0;
    do_reset();
    cycle(1, 8'h00, 1, 4'h0);
    idle_n(4, 1, 4'h0);
    cycle(1, 8'h40, 1, 4'h0); cycle(1, 8'h5A, 1, 4'h0);
    idle_n(4, 1, 4'h0);
    cycle(1, 8'h91, 1, 4'b0100); cycle(1, 8'h10, 1, 4'b0100);
    idle_n(4, 1, 4'b0100);
    cycle(1, 8'h91, 1, 4'h0); cycle(1, 8'h10, 1, 4'h0);
    idle_n(4, 1, 4'h0);
    f0 = got_ferr;
    cycle(1, 8'h40, 1, 4'h0);
    idle_n(TO + 5, 1, 4'h0);
    chk("frame_err_once", got_ferr - f0, 1);
    cycle(1, 8'h20, 1, 4'h0);
    idle_n(4, 1, 4'h0);
    o0 = got_ovf;
    cycle(1, 8'h10, 0, 4'h0); cycle(1, 8'h20, 0, 4'h0); cycle(1, 8'h30, 0, 4'h0);
    cycle(1, 8'h60, 0, 4'h0); cycle(1, 8'h70, 0, 4'h0);
    idle_n(3, 0, 4'h0);
    chk("level_full", fifo_level, 4);
    chk("rx_ready_full", rx_ready, 0);
    chk("ovf_once", got_ovf - o0, 1);
    idle_n(8, 1, 4'h0);
    cycle(1, 8'h10, 0, 4'h0); cycle(1, 8'h20, 0, 4'h0); cycle(1, 8'h50, 0, 4'h0);
    do_reset();
    idle_n(5, 1, 4'h0);
    cycle(1, 8'h30, 1, 4'h0);
    idle_n(4, 1, 4'h0);
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      if ($urandom_range(0, 99) == 0) idle_n(TO + 2, 1'($urandom_range(0, 1)), 4'($urandom));
      cycle(1'($urandom_range(0, 2) == 0), 8'($urandom),
            (i / 150) % 2 == 0 ? 1'($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 4) == 0),
            4'($urandom));
    end
    idle_n(12, 1, 4'h0);
    chk("drain_empty", exq.size(), 0);
    chk("ovf_count", got_ovf, exp_ovf);
    chk("frame_err_count", got_ferr, exp_ferr);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
